bcd_stopwatch_ctrl: RTL and testbench

Controller that sequences a 4-digit cascaded BCD count chain (0000-9999) as a stopwatch. It has a start/stop/clear FSM, a tick prescaler, digit-carry sequencing, wrap detection and a lap-freeze display path. It sits above the single-digit BCD counters and drives the display logic.

---
 rtl/bcd_stopwatch_ctrl.sv | 145 ++++++++++++++
 tb/tb_bcd_stopwatch_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: start/stop/clear stopwatch sequencing a 4-digit BCD
// count chain (0000-9999) with a tick prescaler, rollover pulse and a
// lap-freeze display path.
module bcd_stopwatch_ctrl #(
  parameter int TICK_DIV = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] count,
  output logic [15:0] disp,
  output logic        running,
  output logic        lap_active,
  output logic        wrap
);

  // Prescaler is at least one bit wide so TICK_DIV=1 still elaborates.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [15:0]     count_q, count_d;
  logic [15:0]     lap_reg_q, lap_reg_d;
  logic            lap_active_q, lap_active_d;
  logic            wrap_q, wrap_d;
  logic            running_q, running_d;
  logic            tick;

  // Ripple a +1 through four BCD digits; a digit at 9 rolls to 0 and
  // passes the carry up. 9999 naturally becomes 0000.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Next-state, prescaler, digit chain and lap logic.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    count_d      = count_q;
    lap_reg_d    = lap_reg_q;
    lap_active_d = lap_active_q;
    wrap_d       = 1'b0;

    // stop/clear in the same cycle suppress the tick and freeze the
    // prescaler, so a later resume fires on its first RUN cycle.
    tick = (state_q == RUN) && (presc_q == PRESC_MAX) && !stop && !clear;

    // Lap toggles on every sampled high level; capture uses the pre-edge
    // count so a coincident tick does not leak into the frozen value.
    if ((state_q != IDLE) && !clear && lap) begin
      lap_active_d = !lap_active_q;
      if (!lap_active_q) begin
        lap_reg_d = count_q;
      end
    end

    if (tick) begin
      count_d = bcd_inc(count_q);
      presc_d = '0;
      wrap_d  = (count_q == 16'h9999);
    end else if ((state_q == RUN) && !stop && !clear) begin
      presc_d = presc_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!clear && !stop && start) begin
          state_d = RUN;
        end
      end
      RUN, PAUSE: begin
        if (clear) begin
          state_d      = IDLE;
          count_d      = '0;
          presc_d      = '0;
          lap_reg_d    = '0;
          lap_active_d = 1'b0;
        end else if (stop) begin
          if (state_q == RUN) begin
            state_d = PAUSE;
          end
        end else if (start) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    running_d = (state_d == RUN);
  end

  // State register with synchronous reset overriding every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      count_q      <= '0;
      lap_reg_q    <= '0;
      lap_active_q <= 1'b0;
      wrap_q       <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      count_q      <= count_d;
      lap_reg_q    <= lap_reg_d;
      lap_active_q <= lap_active_d;
      wrap_q       <= wrap_d;
      running_q    <= running_d;
    end
  end

  assign count      = count_q;
  assign disp       = lap_active_q ? lap_reg_q : count_q;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: three instances (TICK_DIV 1, 2, 4) share
// one randomized input stream and are compared each cycle against an
// integer-count reference model.
module tb_bcd_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst, start, stop, clear, lap;

  logic [15:0] count0, disp0, count1, disp1, count2, disp2;
  logic        run0, lapa0, wrap0, run1, lapa1, wrap1, run2, lapa2, wrap2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_stopwatch_ctrl #(.TICK_DIV(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .count(count0), .disp(disp0), .running(run0), .lap_active(lapa0), .wrap(wrap0)
  );
  bcd_stopwatch_ctrl #(.TICK_DIV(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .count(count1), .disp(disp1), .running(run1), .lap_active(lapa1), .wrap(wrap1)
  );
  bcd_stopwatch_ctrl #(.TICK_DIV(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .count(count2), .disp(disp2), .running(run2), .lap_active(lapa2), .wrap(wrap2)
  );

  // Reference model: mode 0=IDLE 1=RUN 2=PAUSE, count held as an integer.
  int div [3] = '{1, 2, 4};
  int m_mode [3];
  int m_cnt  [3];
  int m_pre  [3];
  int m_lapv [3];
  int m_lapa [3];
  int m_wrap [3];
  int m_run  [3];
  int wraps_seen0 = 0;
  int wraps_model0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = 0; m_cnt[i] = 0; m_pre[i] = 0;
      m_lapv[i] = 0; m_lapa[i] = 0; m_wrap[i] = 0; m_run[i] = 0;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      bit tk;
      int mode;
      mode = m_mode[i];
      tk = (mode == 1) && (m_pre[i] == div[i] - 1) && !stop && !clear;
      if (mode != 0 && !clear && lap) begin
        if (m_lapa[i] == 0) m_lapv[i] = m_cnt[i];
        m_lapa[i] = 1 - m_lapa[i];
      end
      m_wrap[i] = (tk && m_cnt[i] == 9999) ? 1 : 0;
      if (tk) begin
        m_cnt[i] = (m_cnt[i] + 1) % 10000;
        m_pre[i] = 0;
      end else if (mode == 1 && !stop && !clear) begin
        m_pre[i] = m_pre[i] + 1;
      end
      if (clear) begin
        m_mode[i] = 0; m_cnt[i] = 0; m_pre[i] = 0; m_lapv[i] = 0; m_lapa[i] = 0;
      end else if (stop) begin
        if (mode == 1) m_mode[i] = 2;
      end else if (start) begin
        m_mode[i] = 1;
      end
      m_run[i] = (m_mode[i] == 1) ? 1 : 0;
    end
    if (m_wrap[0] != 0) wraps_model0++;
  endtask

  task automatic check_inst(input int i, input logic [15:0] c, input logic [15:0] d,
                            input logic r, input logic la, input logic w);
    logic [15:0] exp_c, exp_d;
    exp_c = to_bcd(m_cnt[i]);
    exp_d = (m_lapa[i] != 0) ? to_bcd(m_lapv[i]) : exp_c;
    chk($sformatf("i%0d_count", i), 32'(c), 32'(exp_c));
    chk($sformatf("i%0d_disp", i), 32'(d), 32'(exp_d));
    chk($sformatf("i%0d_running", i), 32'(r), 32'(m_run[i]));
    chk($sformatf("i%0d_lap_active", i), 32'(la), 32'(m_lapa[i]));
    chk($sformatf("i%0d_wrap", i), 32'(w), 32'(m_wrap[i]));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    if (wrap0) wraps_seen0++;
    check_inst(0, count0, disp0, run0, lapa0, wrap0);
    check_inst(1, count1, disp1, run1, lapa1, wrap1);
    check_inst(2, count2, disp2, run2, lapa2, wrap2);
  endtask

  task automatic drive(input logic r, input logic sa, input logic so,
                       input logic cl, input logic lp);
    rst = r; start = sa; stop = so; clear = cl; lap = lp;
  endtask

  initial begin
    model_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset held with start asserted.
    repeat (2) step();

    // Plain run: count advances at each instance's own rate.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) step();

    // Stop, hold, resume to exercise the held partial period.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) step();

    // Lap freeze and release, including a held lap level.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // All three commands at once in RUN, then reset mid-RUN.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) step();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();

    // Randomized command stream.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 499) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 63) == 0),
            ($urandom_range(0, 9) == 0));
      step();
    end

    // Long free run so the TICK_DIV=1 instance rolls over 9999 -> 0000.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10005) step();
    chk("wrap_pulse_count", 32'(wraps_seen0), 32'(wraps_model0));
    chk("wrap_reached", 32'(wraps_seen0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
